// File: rtl/mult_share_arb.sv
// Round-robin arbiter that time-shares one external signed multiplier among NREQ requesters.
// A tag pipeline matched to the multiplier latency routes each product back to its issuer.
module mult_share_arb #(
    parameter int NREQ = 4,
    parameter int AW   = 16,
    parameter int BW   = 16,
    parameter int MW   = AW + BW,
    parameter int LAT  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_subadd,
    input  logic [NREQ*AW-1:0] req_a,
    input  logic [NREQ*BW-1:0] req_b,
    output logic               m_subadd,
    output logic [AW-1:0]      m_ain,
    output logic [BW-1:0]      m_bin,
    input  logic [MW-1:0]      m_pout,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [MW-1:0]      rsp_data,
    output logic               busy
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

    logic [IW-1:0]   ptr;
    logic [IW-1:0]   ptr_nx;
    logic [IW-1:0]   gid;
    logic [IW-1:0]   idx;
    logic [IW:0]     sum;
    logic            found;
    logic            hs;
    logic [NREQ-1:0] grant;
    logic            sel_s;
    logic [AW-1:0]   sel_a;
    logic [BW-1:0]   sel_b;
    logic [LAT:0]    tag_v;
    logic [IW-1:0]   tag_id [LAT+1];

    // First valid requester at or after the pointer, with wrap-around.
    always_comb begin
        grant = '0;
        gid   = '0;
        idx   = '0;
        sum   = '0;
        found = 1'b0;
        if (en && !rst) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                sum = {1'b0, ptr} + (IW+1)'(k);
                idx = (sum >= NREQ_W) ? IW'(sum - NREQ_W) : IW'(sum);
                if (!found && req_valid[idx]) begin
                    found = 1'b1;
                    gid   = idx;
                end
            end
            if (found) begin
                grant[gid] = 1'b1;
            end
        end
    end

    // Operand select; all-zero when nothing is granted.
    always_comb begin
        sel_s = 1'b0;
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_s = req_subadd[i];
                sel_a = req_a[i*AW +: AW];
                sel_b = req_b[i*BW +: BW];
            end
        end
    end

    assign hs        = found;
    assign ptr_nx    = (gid == IW'(NREQ - 1)) ? '0 : gid + 1'b1;
    assign req_ready = grant;
    assign busy      = (|tag_v) | (|rsp_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            m_subadd  <= 1'b0;
            m_ain     <= '0;
            m_bin     <= '0;
            tag_v     <= '0;
            for (int unsigned s = 0; s <= LAT; s++) begin
                tag_id[s] <= '0;
            end
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            m_subadd <= sel_s;
            m_ain    <= sel_a;
            m_bin    <= sel_b;
            if (hs) begin
                ptr <= ptr_nx;
            end
            // Tag at index LAT lines up with m_pout for the op issued LAT+1 edges ago.
            tag_v     <= {tag_v[LAT-1:0], hs};
            tag_id[0] <= gid;
            for (int unsigned s = 1; s <= LAT; s++) begin
                tag_id[s] <= tag_id[s-1];
            end
            if (tag_v[LAT]) begin
                rsp_valid <= NREQ'(1) << tag_id[LAT];
                rsp_data  <= m_pout;
            end else begin
                rsp_valid <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mult_share_arb.sv
// Self-checking bench for mult_share_arb: a multiplier stub plus a queue-based reference
// model of grants and returned products, driven by directed and randomized stimulus.
module tb_mult_share_arb;
    localparam int NREQ = 4;
    localparam int AW   = 16;
    localparam int BW   = 16;
    localparam int MW   = AW + BW;
    localparam int LAT  = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_subadd;
    logic [NREQ*AW-1:0] req_a;
    logic [NREQ*BW-1:0] req_b;
    logic               m_subadd;
    logic [AW-1:0]      m_ain;
    logic [BW-1:0]      m_bin;
    logic [MW-1:0]      m_pout;
    logic [NREQ-1:0]    rsp_valid;
    logic [MW-1:0]      rsp_data;
    logic               busy;

    always #5 clk = ~clk;

    mult_share_arb #(.NREQ(NREQ), .AW(AW), .BW(BW), .MW(MW), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_ready(req_ready), .req_subadd(req_subadd),
        .req_a(req_a), .req_b(req_b),
        .m_subadd(m_subadd), .m_ain(m_ain), .m_bin(m_bin), .m_pout(m_pout),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
    );

    // Stand-in for the shared multiplier: LAT register stages from operands to pout.
    logic signed [MW-1:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= m_subadd ? -($signed(m_ain) * $signed(m_bin)) : $signed(m_ain) * $signed(m_bin);
        for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
    end
    assign m_pout = mpipe[LAT-1];

    typedef struct {
        int          due;
        int          id;
        logic [MW-1:0] val;
    } exp_t;

    exp_t          q[$];
    int            ptr_m;
    int            ncyc;
    logic [MW-1:0] last_rd;
    int            total;
    int            bad;

    logic [NREQ-1:0] er, gr, ev;
    logic [MW-1:0]   ed;
    logic            eb;

    function automatic logic [NREQ-1:0] ref_grant();
        int i;
        if (!en || rst) return '0;
        for (int k = 0; k < NREQ; k++) begin
            i = (ptr_m + k) % NREQ;
            if (req_valid[i]) return NREQ'(1) << i;
        end
        return '0;
    endfunction

    function automatic logic [MW-1:0] ref_prod(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic s);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        if (s) p = -p;
        return p[MW-1:0];
    endfunction

    // Advance one clock: capture observed grant, update the model, return expectations at the next negedge.
    task automatic step(output logic [NREQ-1:0] xr, output logic [NREQ-1:0] or_, output logic [NREQ-1:0] xv,
                        output logic [MW-1:0] xd, output logic xb);
        exp_t e;
        int   gi;
        #1;
        xr  = ref_grant();
        or_ = req_ready;
        gi  = -1;
        for (int i = 0; i < NREQ; i++) if (xr[i]) gi = i;
        if (gi >= 0) begin
            e.id  = gi;
            e.val = ref_prod(req_a[gi*AW +: AW], req_b[gi*BW +: BW], req_subadd[gi]);
        end
        @(posedge clk);
        ncyc++;
        if (gi >= 0) begin
            e.due = ncyc + LAT + 1;
            q.push_back(e);
            ptr_m = (gi + 1) % NREQ;
        end
        xv = '0;
        xd = last_rd;
        if (q.size() > 0 && q[0].due == ncyc) begin
            xv      = NREQ'(1) << q[0].id;
            xd      = q[0].val;
            last_rd = xd;
            void'(q.pop_front());
        end
        xb = (q.size() > 0) || (xv != '0);
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [BW-1:0] b, input logic s);
        req_valid[i]        = v;
        req_a[i*AW +: AW]   = a;
        req_b[i*BW +: BW]   = b;
        req_subadd[i]       = s;
    endtask

    task automatic model_clear();
        q.delete();
        ptr_m   = 0;
        last_rd = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_clear();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        en = 1'b1;
        req_valid = '0;
        set_req(1, 1'b1, 16'd5, 16'd5, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        if ({req_ready, m_subadd, m_ain, m_bin, rsp_valid, rsp_data, busy} !== '0) begin
            bad++;
            $display("FAIL reset_state: rdy=%b m=%b/%h/%h rv=%b rd=%h busy=%b, all required 0",
                     req_ready, m_subadd, m_ain, m_bin, rsp_valid, rsp_data, busy);
        end
        total++;
        model_clear();
        req_valid = '0;
        rst = 1'b0;
    endtask

    task automatic test_single();
        set_req(2, 1'b1, 16'd7, -16'sd3, 1'b0);
        for (int k = 0; k < LAT + 3; k++) begin
            step(er, gr, ev, ed, eb);
            if ({gr, rsp_valid, rsp_data, busy} !== {er, ev, ed, eb}) begin
                bad++;
                $display("FAIL single c%0d: rdy %b exp %b, rv %b exp %b, rd %0d exp %0d, busy %b exp %b",
                         ncyc, gr, er, rsp_valid, ev, $signed(rsp_data), $signed(ed), busy, eb);
            end
            total++;
            if (k == 0) begin
                if (gr !== 4'b0100 || m_ain !== 16'd7) begin
                    bad++;
                    $display("FAIL single_grant: rdy %b m_ain %0d, required 0100 and 7", gr, $signed(m_ain));
                end
                total++;
                req_valid = '0;
            end
            if (ev != '0) begin
                if (rsp_valid !== 4'b0100 || rsp_data !== -32'sd21) begin
                    bad++;
                    $display("FAIL single_result: rv %b rd %0d, required 0100 and -21", rsp_valid, $signed(rsp_data));
                end
                total++;
            end
        end
    endtask

    task automatic test_negation();
        set_req(0, 1'b1, -16'sd10, -16'sd10, 1'b1);
        for (int k = 0; k < LAT + 3; k++) begin
            step(er, gr, ev, ed, eb);
            if ({gr, rsp_valid, rsp_data, busy} !== {er, ev, ed, eb}) begin
                bad++;
                $display("FAIL negation c%0d: rdy %b exp %b, rv %b exp %b, rd %0d exp %0d, busy %b exp %b",
                         ncyc, gr, er, rsp_valid, ev, $signed(rsp_data), $signed(ed), busy, eb);
            end
            total++;
            req_valid = req_valid & ~gr;
            if (ev != '0) begin
                if (rsp_valid !== 4'b0001 || rsp_data !== -32'sd100) begin
                    bad++;
                    $display("FAIL negation_result: rv %b rd %0d, required 0001 and -100", rsp_valid, $signed(rsp_data));
                end
                total++;
            end
        end
    endtask

    task automatic test_contention();
        apply_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(i + 1), 16'd2, 1'b0);
        for (int k = 0; k < 3*NREQ + LAT + 2; k++) begin
            step(er, gr, ev, ed, eb);
            if ({gr, rsp_valid, rsp_data, busy} !== {er, ev, ed, eb}) begin
                bad++;
                $display("FAIL contention c%0d: rdy %b exp %b, rv %b exp %b, rd %0d exp %0d, busy %b exp %b",
                         ncyc, gr, er, rsp_valid, ev, $signed(rsp_data), $signed(ed), busy, eb);
            end
            total++;
            if (k < 3*NREQ) begin
                if (gr !== NREQ'(1) << (k % NREQ)) begin
                    bad++;
                    $display("FAIL contention_order k%0d: rdy %b, required %b", k, gr, NREQ'(1) << (k % NREQ));
                end
                total++;
            end
            if (k >= 2*NREQ) req_valid = req_valid & ~gr;
        end
    endtask

    task automatic test_extremes();
        set_req(1, 1'b1, 16'h8000, 16'h8000, 1'b0);
        set_req(3, 1'b1, 16'h8000, 16'h8000, 1'b1);
        for (int k = 0; k < LAT + 5; k++) begin
            step(er, gr, ev, ed, eb);
            if ({gr, rsp_valid, rsp_data, busy} !== {er, ev, ed, eb}) begin
                bad++;
                $display("FAIL extremes c%0d: rdy %b exp %b, rv %b exp %b, rd %0d exp %0d, busy %b exp %b",
                         ncyc, gr, er, rsp_valid, ev, $signed(rsp_data), $signed(ed), busy, eb);
            end
            total++;
            req_valid = req_valid & ~gr;
            if (ev[1] && rsp_data !== 32'sd1073741824) begin
                bad++;
                $display("FAIL extremes_pos: rd %0d, required 1073741824", $signed(rsp_data));
            end
            if (ev[3] && rsp_data !== -32'sd1073741824) begin
                bad++;
                $display("FAIL extremes_neg: rd %0d, required -1073741824", $signed(rsp_data));
            end
            if (ev[1] || ev[3]) total++;
        end
    endtask

    task automatic test_enable();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'($urandom), BW'($urandom), 1'($urandom));
        for (int k = 0; k < 2 + LAT + 3 + NREQ + LAT + 2; k++) begin
            if (k == 2) en = 1'b0;
            if (k == 2 + LAT + 3) en = 1'b1;
            step(er, gr, ev, ed, eb);
            if ({gr, rsp_valid, rsp_data, busy} !== {er, ev, ed, eb}) begin
                bad++;
                $display("FAIL enable c%0d: rdy %b exp %b, rv %b exp %b, rd %0d exp %0d, busy %b exp %b",
                         ncyc, gr, er, rsp_valid, ev, $signed(rsp_data), $signed(ed), busy, eb);
            end
            total++;
            req_valid = req_valid & ~gr;
            if (k >= 2 && k < 2 + LAT + 3) begin
                if (gr !== '0) begin
                    bad++;
                    $display("FAIL enable_block k%0d: rdy %b, required 0000", k, gr);
                end
                total++;
            end
            if (k == 2 + LAT + 2) begin
                if (busy !== 1'b0) begin
                    bad++;
                    $display("FAIL enable_drain: busy %b, required 0", busy);
                end
                total++;
            end
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        for (int k = 0; k < 400; k++) begin
            step(er, gr, ev, ed, eb);
            if ({gr, rsp_valid, rsp_data, busy} !== {er, ev, ed, eb}) begin
                bad++;
                $display("FAIL random c%0d: rdy %b exp %b, rv %b exp %b, rd %0d exp %0d, busy %b exp %b",
                         ncyc, gr, er, rsp_valid, ev, $signed(rsp_data), $signed(ed), busy, eb);
            end
            total++;
            for (int i = 0; i < NREQ; i++) begin
                if (gr[i] || !req_valid[i]) begin
                    case ($urandom_range(0, 3))
                        0:       a = 16'h8000;
                        1:       a = 16'h7fff;
                        default: a = AW'($urandom);
                    endcase
                    b = ($urandom_range(0, 3) == 0) ? 16'h8000 : BW'($urandom);
                    set_req(i, 1'($urandom_range(0, 2) != 0), a, b, 1'($urandom));
                end
            end
            en = ($urandom_range(0, 9) != 0);
        end
        en = 1'b1;
        for (int k = 0; k < 2*NREQ + LAT + 2; k++) begin
            step(er, gr, ev, ed, eb);
            if ({gr, rsp_valid, rsp_data, busy} !== {er, ev, ed, eb}) begin
                bad++;
                $display("FAIL random_drain c%0d: rdy %b exp %b, rv %b exp %b, rd %0d exp %0d, busy %b exp %b",
                         ncyc, gr, er, rsp_valid, ev, $signed(rsp_data), $signed(ed), busy, eb);
            end
            total++;
            req_valid = req_valid & ~gr;
        end
    endtask

    task automatic test_reset_midflight();
        req_valid = '0;
        set_req(2, 1'b1, 16'd9, 16'd9, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step(er, gr, ev, ed, eb);
            if ({gr, rsp_valid, rsp_data, busy} !== {er, ev, ed, eb}) begin
                bad++;
                $display("FAIL midflight_pre c%0d: rdy %b exp %b, rv %b exp %b, rd %0d exp %0d, busy %b exp %b",
                         ncyc, gr, er, rsp_valid, ev, $signed(rsp_data), $signed(ed), busy, eb);
            end
            total++;
            req_valid = req_valid & ~gr;
        end
        set_req(0, 1'b1, 16'd3, 16'd4, 1'b0);
        set_req(3, 1'b1, 16'd5, 16'd6, 1'b1);
        rst = 1'b1;
        #1;
        if ({req_ready, m_subadd, m_ain, m_bin, rsp_valid, rsp_data, busy} !== '0) begin
            bad++;
            $display("FAIL midflight_async: rdy=%b m=%b/%h/%h rv=%b rd=%h busy=%b, all required 0",
                     req_ready, m_subadd, m_ain, m_bin, rsp_valid, rsp_data, busy);
        end
        total++;
        model_clear();
        repeat (LAT + 2) @(posedge clk);
        @(negedge clk);
        if ({rsp_valid, rsp_data, busy} !== '0) begin
            bad++;
            $display("FAIL midflight_hold: rv=%b rd=%h busy=%b, all required 0", rsp_valid, rsp_data, busy);
        end
        total++;
        rst = 1'b0;
        for (int k = 0; k < LAT + 5; k++) begin
            step(er, gr, ev, ed, eb);
            if ({gr, rsp_valid, rsp_data, busy} !== {er, ev, ed, eb}) begin
                bad++;
                $display("FAIL midflight_post c%0d: rdy %b exp %b, rv %b exp %b, rd %0d exp %0d, busy %b exp %b",
                         ncyc, gr, er, rsp_valid, ev, $signed(rsp_data), $signed(ed), busy, eb);
            end
            total++;
            if (k == 0) begin
                if (gr !== 4'b0001) begin
                    bad++;
                    $display("FAIL midflight_first_grant: rdy %b, required 0001", gr);
                end
                total++;
            end
            req_valid = req_valid & ~gr;
        end
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        req_valid  = '0;
        req_subadd = '0;
        req_a      = '0;
        req_b      = '0;
        total      = 0;
        bad        = 0;
        ncyc       = 0;
        model_clear();
        test_reset();
        test_single();
        test_negation();
        test_contention();
        test_extremes();
        test_enable();
        test_random();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded 500000 time units, required completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mult_share_arb.md
# mult_share_arb

Round-robin arbiter and scheduler that time-shares one `dynamic_neg_mult` instance (signed `ain*bin`, optionally negated by `subadd`) among `NREQ` requesters. It accepts at most one operation per cycle, drives the registered operand ports of the shared multiplier and tracks in-flight operations with a tag pipeline. Each product is returned to the requester that issued it. The block sits between client datapaths (filters, MAC units) and a single multiplier resource.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `AW`, 16: signed operand A width.
- `BW`, 16: signed operand B width.
- `MW`, AW+BW: product width.
- `LAT`, 3: multiplier latency in cycles, from operands at its inputs to `pout` valid (≥1).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: grant enable; low blocks new grants, in-flight operations still drain.
- `req_valid` input NREQ: per-requester request.
- `req_ready` output NREQ: per-requester grant, at most one bit set.
- `req_subadd` input NREQ: 1 = negate the product.
- `req_a` input NREQ*AW: packed signed A operands, requester i at [i*AW +: AW].
- `req_b` input NREQ*BW: packed signed B operands.
- `m_subadd`, `m_ain`, `m_bin` output 1/AW/BW: registered drive to the multiplier.
- `m_pout` input MW: multiplier result.
- `rsp_valid` output NREQ: one-hot result strobe, one cycle per result.
- `rsp_data` output MW: registered product.
- `busy` output 1: any operation in flight.

## Operation
- Reset values: `req_ready`=0, `m_*`=0, `rsp_valid`=0, `rsp_data`=0, `busy`=0. The round-robin pointer resets to 0. All tags are cleared, so any in-flight result is discarded and never strobed.
- Grant is combinational: `req_ready[i]`=1 when `en`=1 and i is the first requester with `req_valid` set, searching from the pointer upward with wrap-around.
  - `req_ready` may depend on `req_valid`.
  - Requesters hold `req_valid` and operands stable until they see `req_ready`. They must not drop `req_valid` before it.
- A handshake (`req_valid[i] & req_ready[i]`) registers the operands and `req_subadd[i]` into `m_*`. It also pushes tag {valid=1, id=i} into a shift register of depth LAT+1. The pointer advances to (i+1) mod NREQ.
- With no handshake, `m_*` are driven to 0 and a tag with valid=0 is pushed. The pointer holds.
- When the tag at the pipeline end has valid=1:
  - `rsp_data` takes `m_pout`.
  - `rsp_valid` is set to one-hot(id) for one cycle.
- When that tag has valid=0, `rsp_valid`=0 and `rsp_data` holds its last value.
- Results return in issue order. There is no response backpressure; clients must accept every `rsp_valid`.
- Arithmetic belongs to the multiplier: `rsp_data` = subadd ? −(a·b) : a·b, full MW bits, signed. MW=AW+BW holds every result without overflow, including −(−2^(AW−1)·−2^(BW−1)).
- `busy` = OR of all tag valid bits plus `rsp_valid` pending.
- `en` falling mid-stream: no new `req_ready` from that cycle onward. Tags already issued complete normally.
- Simultaneous events:
  - All requesters valid at once: served in pointer order, one per cycle, with no starvation.
  - A requester granted last cycle and still valid is served again only after every other valid requester.

## Timing
- Handshake at rising edge t: `m_*` valid after edge t.
- Multiplier `pout` valid after edge t+LAT.
- `rsp_valid`/`rsp_data` valid after edge t+LAT+1, so total latency is LAT+1 edges from handshake.
- Throughput is 1 operation per cycle sustained. Per-requester throughput is 1/NREQ under full contention.
- Async `rst` clears all state immediately. The first grant is possible in the first cycle after `rst` deasserts.

## Test plan
- Single op: req 2 valid with a=7, b=−3, subadd=0. Expect `req_ready`=4'b0100 the same cycle, and after LAT+1 edges `rsp_valid`=4'b0100 with `rsp_data`=−21.
- Negation: req 0 with a=−10, b=−10, subadd=1. Expect `rsp_data`=−100 on `rsp_valid`[0].
- Full contention: all 4 valid continuously with a=i+1, b=2 after reset. Expect grants in order 0,1,2,3,0,… on consecutive cycles, and results 2,4,6,8 strobed in that order on consecutive cycles.
- Extremes: a=−32768, b=−32768. Expect 1073741824 with subadd=0 and −1073741824 with subadd=1.
- Enable: with 2 ops issued, drop `en`. Expect `req_ready`=0 while both results still appear, then `busy` falls to 0. Raising `en` resumes from the pointer.
- Reset mid-flight: assert `rst` 1 cycle after a handshake. Expect `rsp_valid` to stay 0 with no stale result, all outputs at reset values, and the first grant after release going to requester 0.
